// File: rtl/ad9945_cfg_ctrl.sv
// AD9945 AFE configuration sequencer: shadows Oper/Ctrl/Clamp/VGA_Gain and
// serializes dirty registers over the SL/SCK/SDATA 3-wire port, LSB first.
module ad9945_cfg_ctrl #(
  parameter int SCK_DIV = 10
) (
  input  logic       sys_clk,
  input  logic       resetn,
  input  logic       cfg_en,
  input  logic [6:0] Oper,
  input  logic [6:0] Ctrl,
  input  logic [7:0] Clamp,
  input  logic [9:0] VGA_Gain,
  output logic       SL,
  output logic       SCK,
  output logic       SDATA,
  output logic       cfg_busy,
  output logic       cfg_done
);

  typedef enum logic [2:0] {IDLE, SELECT, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [8:0] DIV_M1 = 9'(SCK_DIV - 1);
  localparam logic [8:0] GAP_M1 = 9'(2 * SCK_DIV - 1);

  state_t      state, state_nx;
  logic [8:0]  cnt;
  logic [3:0]  bit_idx;
  logic        phase;
  logic [15:0] sreg;
  logic [11:0] shadow [4];
  logic [11:0] in_val [4];
  logic [3:0]  dirty, dirty_nx;
  logic [1:0]  sel;
  logic        en_d;
  logic        done;
  logic        cnt_last;
  logic        more;

  assign in_val[0] = {5'd0, Oper};
  assign in_val[1] = {5'd0, Ctrl};
  assign in_val[2] = {4'd0, Clamp};
  assign in_val[3] = {2'd0, VGA_Gain};

  assign cnt_last = (state == GAP) ? (cnt == GAP_M1) : (cnt == DIV_M1);
  assign more     = en_d && (dirty != 4'd0);

  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (dirty[i]) sel = i[1:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (more) state_nx = SELECT;
      SELECT:  state_nx = SETUP;
      SETUP:   if (cnt_last) state_nx = SHIFT;
      SHIFT:   if (cnt_last && phase && bit_idx == 4'd15) state_nx = HOLD;
      HOLD:    if (cnt_last) state_nx = GAP;
      GAP:     if (cnt_last) state_nx = more ? SELECT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Rising edge of cfg_en marks everything dirty; the register being loaded
  // in SELECT is cleared since its shadow takes the current input value.
  always_comb begin
    dirty_nx = dirty;
    if (cfg_en && !en_d) begin
      dirty_nx = 4'hF;
    end else if (!en_d) begin
      dirty_nx = 4'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (state == SELECT && sel == i[1:0]) dirty_nx[i] = 1'b0;
        else if (in_val[i] != shadow[i])     dirty_nx[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      phase   <= 1'b0;
      sreg    <= '0;
      dirty   <= '0;
      en_d    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
    end else begin
      state <= state_nx;
      en_d  <= cfg_en;
      dirty <= dirty_nx;
      done  <= (state == GAP) && cnt_last && !more && en_d;
      cnt   <= (state_nx != state || cnt_last || state == IDLE) ? 9'd0 : cnt + 9'd1;
      if (state == SELECT) begin
        shadow[sel] <= in_val[sel];
        sreg        <= {in_val[sel], 2'b00, sel};
        bit_idx     <= '0;
        phase       <= 1'b0;
      end else if (state == SHIFT && cnt_last) begin
        phase <= ~phase;
        // Advance data only as SCK returns low, never during the high phase.
        if (phase) begin
          sreg    <= {1'b0, sreg[15:1]};
          bit_idx <= bit_idx + 4'd1;
        end
      end else if (state != SHIFT) begin
        phase <= 1'b0;
      end
    end
  end

  assign SL       = !(state == SETUP || state == SHIFT || state == HOLD);
  assign SCK      = (state == SHIFT) && phase;
  assign SDATA    = !SL && sreg[0];
  assign cfg_busy = (state != IDLE);
  assign cfg_done = done;

endmodule

// File: tb/tb_ad9945_cfg_ctrl.sv
// Directed bench for ad9945_cfg_ctrl: decodes SL/SCK/SDATA frames and checks
// words, frame timing, busy length and done pulses against hand values.
module tb_ad9945_cfg_ctrl;

  logic       sys_clk = 1'b0;
  logic       resetn  = 1'b1;
  logic       cfg_en  = 1'b0;
  logic [6:0] Oper    = '0;
  logic [6:0] Ctrl    = '0;
  logic [7:0] Clamp   = '0;
  logic [9:0] VGA_Gain = '0;
  logic       SL, SCK, SDATA, cfg_busy, cfg_done;

  int n_tests = 0;
  int n_fail  = 0;

  ad9945_cfg_ctrl #(.SCK_DIV(10)) dut (
    .sys_clk (sys_clk),
    .resetn  (resetn),
    .cfg_en  (cfg_en),
    .Oper    (Oper),
    .Ctrl    (Ctrl),
    .Clamp   (Clamp),
    .VGA_Gain(VGA_Gain),
    .SL      (SL),
    .SCK     (SCK),
    .SDATA   (SDATA),
    .cfg_busy(cfg_busy),
    .cfg_done(cfg_done)
  );

  always #5 sys_clk = ~sys_clk;

  // Frame monitor, sampled on the falling clock edge.
  logic        sl_prev = 1'b1, sck_prev = 1'b0, sd_prev = 1'b0;
  logic [15:0] word = '0;
  int          nfalls = 0, bits = 0, sl_len = 0, busy_cyc = 0, done_cnt = 0;
  int          sck_total = 0, sd_viol = 0;
  logic [15:0] words[$];
  int          rises_q[$];
  int          len_q[$];
  logic [15:0] exp_q[$];

  always @(negedge sys_clk) begin
    if (sck_prev && SCK && SDATA !== sd_prev) sd_viol++;
    if (!sck_prev && SCK) begin
      word = {SDATA, word[15:1]};
      bits++;
      sck_total++;
    end
    if (sl_prev && !SL) begin
      nfalls++;
      bits   = 0;
      sl_len = 0;
    end
    if (!SL) sl_len++;
    if (!sl_prev && SL) begin
      words.push_back(word);
      rises_q.push_back(bits);
      len_q.push_back(sl_len);
    end
    if (cfg_busy) busy_cyc++;
    if (cfg_done) done_cnt++;
    sl_prev  = SL;
    sck_prev = SCK;
    sd_prev  = SDATA;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  task automatic clr();
    words.delete();
    rises_q.delete();
    len_q.delete();
    busy_cyc = 0;
    done_cnt = 0;
    nfalls   = 0;
  endtask

  task automatic wait_falls(input string tag, input int target, input int budget);
    int k = 0;
    while (nfalls < target && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, 32'(nfalls >= target), 32'd1);
  endtask

  task automatic chk_frames(input string tag);
    chk({tag, "_count"}, 32'(words.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < words.size(); i++) begin
      chk($sformatf("%s_word%0d", tag, i), 32'(words[i]), 32'(exp_q[i]));
      chk($sformatf("%s_rises%0d", tag, i), 32'(rises_q[i]), 32'd16);
      chk($sformatf("%s_sllen%0d", tag, i), 32'(len_q[i]), 32'd340);
    end
  endtask

  initial begin
    // Reset hold
    #2 resetn = 1'b0;
    step(51);
    chk("rst_SL", 32'(SL), 32'd1);
    chk("rst_SCK", 32'(SCK), 32'd0);
    chk("rst_SDATA", 32'(SDATA), 32'd0);
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    chk("rst_done", 32'(cfg_done), 32'd0);
    chk("rst_sck_edges", 32'(sck_total), 32'd0);
    resetn = 1'b1;
    step(3);

    // Full write
    Oper = 7'h55; Ctrl = 7'h55; Clamp = 8'h55; VGA_Gain = 10'h155;
    clr();
    cfg_en = 1'b1;
    step(1600);
    exp_q = '{16'h0550, 16'h0551, 16'h0552, 16'h1553};
    chk_frames("full");
    chk("full_busy", 32'(busy_cyc), 32'd1444);
    chk("full_done", 32'(done_cnt), 32'd1);
    chk("full_idle", 32'(cfg_busy), 32'd0);

    // Incremental update of VGA_Gain only
    clr();
    VGA_Gain = 10'h2AA;
    step(500);
    exp_q = '{16'h2AA3};
    chk_frames("incr");
    chk("incr_busy", 32'(busy_cyc), 32'd361);
    chk("incr_done", 32'(done_cnt), 32'd1);

    // Clamp changes in the middle of its own frame
    cfg_en = 1'b0;
    step(5);
    clr();
    cfg_en = 1'b1;
    wait_falls("own_wait", 3, 1200);
    step(100);
    Clamp = 8'h33;
    step(2000);
    exp_q = '{16'h0550, 16'h0551, 16'h0552, 16'h0332, 16'h2AA3};
    chk_frames("own");
    chk("own_busy", 32'(busy_cyc), 32'd1805);
    chk("own_done", 32'(done_cnt), 32'd1);

    // Disable during the second frame
    cfg_en = 1'b0;
    step(5);
    clr();
    cfg_en = 1'b1;
    wait_falls("dis_wait", 2, 800);
    step(50);
    cfg_en = 1'b0;
    step(800);
    exp_q = '{16'h0550, 16'h0551};
    chk_frames("dis");
    chk("dis_busy", 32'(busy_cyc), 32'd722);
    chk("dis_done", 32'(done_cnt), 32'd0);
    chk("dis_idle", 32'(cfg_busy), 32'd0);

    // Reset after 5 SCK rises of the first frame
    clr();
    cfg_en = 1'b1;
    wait_falls("mrst_wait", 1, 50);
    begin
      int k = 0;
      while (bits < 5 && k < 400) begin
        step(1);
        k++;
      end
    end
    chk("mrst_bits", 32'(bits), 32'd5);
    resetn = 1'b0;
    #1;
    chk("mrst_SL", 32'(SL), 32'd1);
    chk("mrst_SCK", 32'(SCK), 32'd0);
    chk("mrst_busy", 32'(cfg_busy), 32'd0);
    step(3);
    cfg_en = 1'b0;
    step(2);
    resetn = 1'b1;
    step(3);
    chk("mrst_partial_cnt", 32'(rises_q.size()), 32'd1);
    if (rises_q.size() > 0) chk("mrst_partial_rises", 32'(rises_q[0]), 32'd5);
    clr();
    cfg_en = 1'b1;
    step(1600);
    exp_q = '{16'h0550, 16'h0551, 16'h0332, 16'h2AA3};
    chk_frames("rerun");
    chk("rerun_busy", 32'(busy_cyc), 32'd1444);
    chk("rerun_done", 32'(done_cnt), 32'd1);
    chk("sdata_stable_high", 32'(sd_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
